// File: rtl/layer_feeder_if.sv
// -----------------------------------------------------------------------------
// layer_feeder_if
// Bundles the control and layer-data signals exchanged between the
// layer_feeder and the surrounding game logic / shift_layer stack.
//   module_en      : freeze control (0 holds everything in the feeder)
//   one_ms_tick    : 1 kHz single-cycle tick
//   scroll_req     : single-cycle request to scroll one layer
//   start          : single-cycle pulse launching the scroll
//   load           : single-cycle pulse committing the new layer
//   layer_map_out  : new top layer map, 1 = ground block
//   block_type_out : per-block type, always a subset of layer_map_out
//   busy           : feeder is outside IDLE
//   layer_count    : number of committed layers, saturating
// slave  : the feeder side
// master : the requester / observer side
// -----------------------------------------------------------------------------
interface layer_feeder_if;
  logic        module_en;
  logic        one_ms_tick;
  logic        scroll_req;
  logic        start;
  logic        load;
  logic [0:6]  layer_map_out;
  logic [0:6]  block_type_out;
  logic        busy;
  logic [15:0] layer_count;

  modport slave (
    input  module_en, one_ms_tick, scroll_req,
    output start, load, layer_map_out, block_type_out, busy, layer_count
  );

  modport master (
    output module_en, one_ms_tick, scroll_req,
    input  start, load, layer_map_out, block_type_out, busy, layer_count
  );
endinterface

// File: rtl/layer_feeder.sv
// -----------------------------------------------------------------------------
// layer_feeder
// Sources the new top-row layer for the shift_layer stack. Each scroll
// request generates a candidate 7-block layer (LFSR or fixed table), accepts
// it only if it has enough blocks and is reachable from the previous layer,
// falls back to repeating the previous map after too many rejects, then
// pulses start, times the scroll in ms ticks and pulses load on the last tick.
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : layer_feeder_if.slave (module_en, one_ms_tick, scroll_req in;
//           start, load, layer_map_out, block_type_out, busy, layer_count out)
//
// Build option:
//   LAYER_FEEDER_FIXED_PATTERN_EN : when defined, candidates come from a fixed
//   8-entry table stepped once per GEN cycle instead of from the LFSR.
// -----------------------------------------------------------------------------
module layer_feeder #(
  parameter int          SCROLL_MS  = 150,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          MIN_BLOCKS = 2,
  parameter int          MAX_RETRY  = 8
) (
  input logic          clk,
  input logic          rst_n,
  layer_feeder_if.slave bus
);

  localparam int MSW = (SCROLL_MS > 1) ? $clog2(SCROLL_MS) : 1;
  localparam int RTW = $clog2(MAX_RETRY + 1);
  localparam logic [MSW-1:0] MS_LAST = MSW'(SCROLL_MS - 1);
  localparam logic [RTW-1:0] RT_LAST = RTW'(MAX_RETRY - 1);
  localparam logic [3:0]     MINB    = 4'(MIN_BLOCKS);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_START, S_SCROLL, S_LOAD
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d, lfsr_nx;
  logic [0:6]      map_q, map_d;
  logic [0:6]      type_q, type_d;
  logic [15:0]     count_q, count_d;
  logic [RTW-1:0]  retry_q, retry_d;
  logic [MSW-1:0]  ms_q, ms_d;
  logic            pending_q, pending_d;
  logic            start_c, load_c;
  logic [0:6]      cand, typ, reach;
  logic            accept;

  function automatic logic [3:0] popcnt7(input logic [0:6] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 7; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  // Galois form, taps x^16+x^14+x^13+x^11
  assign lfsr_nx = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

`ifdef LAYER_FEEDER_FIXED_PATTERN_EN
  logic [2:0] pat_q, pat_d;

  function automatic logic [0:6] pat_lut(input logic [2:0] idx);
    logic [0:6] p;
    case (idx)
      3'd0:    p = 7'b0011100;
      3'd1:    p = 7'b0111110;
      3'd2:    p = 7'b1100011;
      3'd3:    p = 7'b0001111;
      3'd4:    p = 7'b1111000;
      3'd5:    p = 7'b0110110;
      3'd6:    p = 7'b1000001;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  assign cand = pat_lut(pat_q);
  assign typ  = cand & 7'b0101010;
`else
  assign cand = lfsr_q[6:0];
  assign typ  = lfsr_q[13:7] & cand;
`endif

  // Blocks the player can land on: the previous layer widened by one
  // position each side, without wrapping at the edges.
  assign reach  = map_q | (map_q << 1) | (map_q >> 1);
  assign accept = (popcnt7(cand) >= MINB) && ((cand & reach) != 7'b0000000);

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    map_d     = map_q;
    type_d    = type_q;
    count_d   = count_q;
    retry_d   = retry_q;
    ms_d      = ms_q;
    pending_d = pending_q;
    start_c   = 1'b0;
    load_c    = 1'b0;
`ifdef LAYER_FEEDER_FIXED_PATTERN_EN
    pat_d     = pat_q;
`endif
    if (bus.module_en) begin
      lfsr_d = lfsr_nx;
      // One-deep queue; covers requests arriving in the LOAD cycle too.
      if (bus.scroll_req && (state_q != S_IDLE)) pending_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (bus.scroll_req || pending_q) begin
            state_d   = S_GEN;
            pending_d = 1'b0;
            retry_d   = '0;
          end
        end
        S_GEN: begin
`ifdef LAYER_FEEDER_FIXED_PATTERN_EN
          pat_d = pat_q + 3'd1;
`endif
          if (accept) begin
            map_d   = cand;
            type_d  = typ;
            state_d = S_START;
          end else if (retry_q < RT_LAST) begin
            retry_d = retry_q + 1'b1;
          end else begin
            // Fallback: repeat the previous map, all blocks plain.
            type_d  = 7'b0000000;
            state_d = S_START;
          end
        end
        S_START: begin
          start_c = 1'b1;
          ms_d    = '0;
          state_d = S_SCROLL;
        end
        S_SCROLL: begin
          if (bus.one_ms_tick) begin
            if (ms_q == MS_LAST) begin
              load_c  = 1'b1;
              state_d = S_LOAD;
            end else begin
              ms_d = ms_q + 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      map_q     <= 7'b1111111;
      type_q    <= 7'b0000000;
      count_q   <= 16'd0;
      retry_q   <= '0;
      ms_q      <= '0;
      pending_q <= 1'b0;
`ifdef LAYER_FEEDER_FIXED_PATTERN_EN
      pat_q     <= 3'd0;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      map_q     <= map_d;
      type_q    <= type_d;
      count_q   <= count_d;
      retry_q   <= retry_d;
      ms_q      <= ms_d;
      pending_q <= pending_d;
`ifdef LAYER_FEEDER_FIXED_PATTERN_EN
      pat_q     <= pat_d;
`endif
    end
  end

  assign bus.start          = start_c;
  assign bus.load           = load_c;
  assign bus.layer_map_out  = map_q;
  assign bus.block_type_out = type_q;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.layer_count    = count_q;

endmodule
